rf_bank_read_scheduler: RTL and testbench

Arbitrates register-file read requests from NumReq operand collectors onto NumBanks single-read-port register-file banks. Each bank is granted to at most one requester per cycle by a per-bank round-robin arbiter. The scheduler drives the bank read addresses and routes the returned bank data back to the winning collector, tagged with the full register index. It sits between the operand collectors and the banked register file, replacing direct single-port RF access.

---
 rtl/rf_bank_read_scheduler_pkg.sv | 14 +
 rtl/rf_bank_read_scheduler_arb.sv | 42 ++++
 rtl/rf_bank_read_scheduler.sv | 134 +++++++++++++
 tb/tb_rf_bank_read_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rf_bank_read_scheduler_pkg.sv
// Shared types for the banked register-file read path.
// Index/vector widths and the bank read latency live here.
package rf_bank_read_scheduler_pkg;

  localparam int GREG_IDX_W     = 8;
  localparam int VEC_W          = 32;
  localparam int RF_BANK_RD_LAT = 1;
  localparam int DEF_BANKS      = 4;

  typedef logic [GREG_IDX_W-1:0] GRegIdx_t;
  typedef logic [VEC_W-1:0]      Vector_t;
  typedef logic [GREG_IDX_W-$clog2(DEF_BANKS)-1:0] BankRow_t;

endpackage

// File: rtl/rf_bank_read_scheduler_arb.sv
// Per-bank round-robin arbiter with its own last-grant pointer.
// Priority starts one past the last winner; busy banks grant nobody.
module rr_bank_arbiter #(
  parameter  int NumReq = 4,
  localparam int IdW    = $clog2(NumReq)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NumReq-1:0] req_i,
  input  logic              en_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    gntId_o
);

  logic [IdW-1:0] ptr_q;
  logic [IdW-1:0] ptr_d;
  logic [IdW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o   = '0;
    gntId_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = IdW'((int'(ptr_q) + i) % NumReq);
      if (!found && en_i && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gntId_o     = cand;
      end
    end
  end

  assign ptr_d = found ? gntId_o : ptr_q;

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= IdW'(NumReq - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_bank_read_scheduler.sv
// Schedules collector reads onto single-port RF banks and routes
// bank data back to the winning collector three cycles after grant.
module rf_bank_read_scheduler
  import rf_bank_read_scheduler_pkg::*;
#(
  parameter  int NumReq   = 4,
  parameter  int NumBanks = 4,
  parameter  int RegIdxW  = GREG_IDX_W,
  localparam int BankW    = $clog2(NumBanks),
  localparam int RowW     = RegIdxW - BankW,
  localparam int IdW      = $clog2(NumReq)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NumReq-1:0]           reqValid,
  input  logic [NumReq*RegIdxW-1:0]   reqIdx,
  output logic [NumReq-1:0]           reqReady,
  input  logic [NumBanks-1:0]         bankBusy,
  output logic [NumBanks-1:0]         bankRdEn,
  output logic [NumBanks*RowW-1:0]    bankRdAddr,
  input  logic [NumBanks*VEC_W-1:0]   bankRdData,
  output logic [NumReq-1:0]           rspValid,
  output logic [NumReq*RegIdxW-1:0]   rspIdx,
  output logic [NumReq*VEC_W-1:0]     rspData
);

  logic [RegIdxW-1:0] idx [NumReq];
  logic [BankW-1:0]   bnk [NumReq];

  logic [NumReq-1:0]  bReq [NumBanks];
  logic [NumReq-1:0]  bGnt [NumBanks];
  logic [IdW-1:0]     bId  [NumBanks];

  logic [NumBanks-1:0] s1Vld_q, s2Vld_q;
  logic [IdW-1:0]      s1Own_q [NumBanks];
  logic [IdW-1:0]      s2Own_q [NumBanks];
  logic [RegIdxW-1:0]  s1Idx_q [NumBanks];
  logic [RegIdxW-1:0]  s2Idx_q [NumBanks];

  logic [NumReq-1:0]   hit;
  logic [RegIdxW-1:0]  iSel [NumReq];
  Vector_t             dSel [NumReq];

  logic [NumReq-1:0]   rspValid_q;
  logic [RegIdxW-1:0]  rspIdx_q  [NumReq];
  Vector_t             rspData_q [NumReq];

  for (genvar r = 0; r < NumReq; r++) begin : gReq
    assign idx[r] = reqIdx[r*RegIdxW +: RegIdxW];
    assign bnk[r] = idx[r][BankW-1:0];
    assign rspIdx[r*RegIdxW +: RegIdxW] = rspIdx_q[r];
    assign rspData[r*VEC_W +: VEC_W]    = rspData_q[r];
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      for (int r = 0; r < NumReq; r++) begin
        bReq[b][r] = reqValid[r] && (bnk[r] == BankW'(b));
      end
    end
  end

  // Gating with rstn keeps reqReady low and pointers frozen in reset.
  for (genvar b = 0; b < NumBanks; b++) begin : gBank
    rr_bank_arbiter #(.NumReq(NumReq)) u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req_i   (bReq[b]),
      .en_i    (rstn && !bankBusy[b]),
      .gnt_o   (bGnt[b]),
      .gntId_o (bId[b])
    );
    assign bankRdAddr[b*RowW +: RowW] = s1Idx_q[b][RegIdxW-1:BankW];
  end

  always_comb begin
    reqReady = '0;
    for (int b = 0; b < NumBanks; b++) reqReady |= bGnt[b];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1Vld_q <= '0;
      s2Vld_q <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) s1Vld_q[b] <= |bGnt[b];
      s2Vld_q <= s1Vld_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NumBanks; b++) begin
      s1Own_q[b] <= bId[b];
      s1Idx_q[b] <= idx[bId[b]];
      s2Own_q[b] <= s1Own_q[b];
      s2Idx_q[b] <= s1Idx_q[b];
    end
  end

  assign bankRdEn = s1Vld_q;

  // Each collector owns at most one in-flight bank slot per cycle.
  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      hit[r]  = 1'b0;
      iSel[r] = '0;
      dSel[r] = '0;
      for (int b = 0; b < NumBanks; b++) begin
        if (s2Vld_q[b] && s2Own_q[b] == IdW'(r)) begin
          hit[r]  = 1'b1;
          iSel[r] = s2Idx_q[b];
          dSel[r] = bankRdData[b*VEC_W +: VEC_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) rspValid_q <= '0;
    else       rspValid_q <= hit;
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NumReq; r++) begin
      if (hit[r]) begin
        rspIdx_q[r]  <= iSel[r];
        rspData_q[r] <= dSel[r];
      end
    end
  end

  assign rspValid = rspValid_q;

endmodule

// File: tb/tb_rf_bank_read_scheduler.sv
// Random and directed read traffic against a grant/latency model.
// A behavioural bank memory supplies data one cycle after bankRdEn.
module tb_rf_bank_read_scheduler;

  localparam int NR   = 4;
  localparam int NB   = 4;
  localparam int IW   = 8;
  localparam int VW   = 32;
  localparam int RW   = 6;
  localparam int NCYC = 2000;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NR-1:0]    reqValid;
  logic [NR*IW-1:0] reqIdx;
  logic [NR-1:0]    reqReady;
  logic [NB-1:0]    bankBusy;
  logic [NB-1:0]    bankRdEn;
  logic [NB*RW-1:0] bankRdAddr;
  logic [NB*VW-1:0] bankRdData;
  logic [NR-1:0]    rspValid;
  logic [NR*IW-1:0] rspIdx;
  logic [NR*VW-1:0] rspData;

  int nCmp = 0;
  int nBad = 0;

  rf_bank_read_scheduler #(.NumReq(NR), .NumBanks(NB), .RegIdxW(IW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .reqValid   (reqValid),
    .reqIdx     (reqIdx),
    .reqReady   (reqReady),
    .bankBusy   (bankBusy),
    .bankRdEn   (bankRdEn),
    .bankRdAddr (bankRdAddr),
    .bankRdData (bankRdData),
    .rspValid   (rspValid),
    .rspIdx     (rspIdx),
    .rspData    (rspData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input int b, input int row);
    return 32'(32'hC0DE0000 ^ (b * 4096) ^ (row * 257));
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bankRdEn[b])
        bankRdData[b*VW +: VW] <= memf(b, int'(bankRdAddr[b*RW +: RW]));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  bit expEn [0:NCYC+7][0:NB-1];
  int expAd [0:NCYC+7][0:NB-1];
  bit expRv [0:NCYC+7][0:NR-1];
  int expRi [0:NCYC+7][0:NR-1];

  int mptr [NB];
  bit curV [NR];
  int curI [NR];
  bit pend [NR];
  bit gnt  [NR];
  bit busy [NB];
  bit rst;

  initial begin
    rstn = 1'b0;
    reqValid = '0;
    reqIdx = '0;
    bankBusy = '0;
    for (int b = 0; b < NB; b++) mptr[b] = NR - 1;
    for (int r = 0; r < NR; r++) begin
      pend[r] = 1'b0; curV[r] = 1'b0; curI[r] = 0;
    end
    repeat (2) @(posedge clk);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      rst = (c < 2) || (c == 45) ||
            (c >= 52 && $urandom_range(0, 79) == 0);
      for (int b = 0; b < NB; b++) busy[b] = 1'b0;
      if (c >= 36 && c <= 37) busy[0] = 1'b1;
      if (c >= 52)
        for (int b = 0; b < NB; b++) busy[b] = ($urandom_range(0, 4) == 0);
      for (int r = 0; r < NR; r++) begin
        if (!pend[r]) begin
          curV[r] = 1'b0;
          if (c >= 2 && c <= 13) begin
            curV[r] = 1'b1; curI[r] = r * 4 + 2;
          end else if (c == 18) begin
            curV[r] = 1'b1; curI[r] = r;
          end else if (c >= 23 && c <= 30 && r == 0) begin
            curV[r] = 1'b1; curI[r] = (c * 5) % 256;
          end else if (c == 36 && r == 1) begin
            curV[r] = 1'b1; curI[r] = 4;
          end else if (c == 44 && r == 0) begin
            curV[r] = 1'b1; curI[r] = 9;
          end else if (c == 46 && (r == 0 || r == 2)) begin
            curV[r] = 1'b1; curI[r] = r * 16 + 1;
          end else if (c >= 52) begin
            curV[r] = ($urandom_range(0, 2) != 0);
            curI[r] = $urandom_range(0, 255);
          end
        end
      end
      rstn = !rst;
      for (int r = 0; r < NR; r++) begin
        reqValid[r] = curV[r];
        reqIdx[r*IW +: IW] = IW'(curI[r]);
      end
      for (int b = 0; b < NB; b++) bankBusy[b] = busy[b];

      @(negedge clk);
      // Reference: winner is the requester closest after the last grant.
      for (int r = 0; r < NR; r++) gnt[r] = 1'b0;
      if (!rst) begin
        for (int b = 0; b < NB; b++) begin
          int w, bd;
          w = -1; bd = NR;
          if (!busy[b]) begin
            for (int r = 0; r < NR; r++) begin
              int d;
              d = (r - mptr[b] - 1 + 2 * NR) % NR;
              if (curV[r] && curI[r] % NB == b && d < bd) begin
                bd = d; w = r;
              end
            end
          end
          if (w >= 0) begin
            gnt[w] = 1'b1;
            mptr[b] = w;
            expEn[c+1][b] = 1'b1;
            expAd[c+1][b] = curI[w] / NB;
            expRv[c+3][w] = 1'b1;
            expRi[c+3][w] = curI[w];
          end
        end
      end

      for (int r = 0; r < NR; r++)
        chk($sformatf("reqReady[%0d] c%0d", r, c), 64'(reqReady[r]), 64'(gnt[r]));
      for (int b = 0; b < NB; b++) begin
        chk($sformatf("bankRdEn[%0d] c%0d", b, c), 64'(bankRdEn[b]),
            64'(expEn[c][b]));
        if (expEn[c][b])
          chk($sformatf("bankRdAddr[%0d] c%0d", b, c),
              64'(bankRdAddr[b*RW +: RW]), 64'(expAd[c][b]));
      end
      for (int r = 0; r < NR; r++) begin
        chk($sformatf("rspValid[%0d] c%0d", r, c), 64'(rspValid[r]),
            64'(expRv[c][r]));
        if (expRv[c][r]) begin
          chk($sformatf("rspIdx[%0d] c%0d", r, c), 64'(rspIdx[r*IW +: IW]),
              64'(expRi[c][r]));
          chk($sformatf("rspData[%0d] c%0d", r, c), 64'(rspData[r*VW +: VW]),
              64'(memf(expRi[c][r] % NB, expRi[c][r] / NB)));
        end
      end

      if (rst) begin
        for (int b = 0; b < NB; b++) begin
          mptr[b] = NR - 1;
          expEn[c+1][b] = 1'b0;
        end
        for (int k = 1; k <= 3; k++)
          for (int r = 0; r < NR; r++) expRv[c+k][r] = 1'b0;
      end
      for (int r = 0; r < NR; r++) pend[r] = curV[r] && !gnt[r];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
